// File: rtl/hazard_ctl.sv
// Pipeline sequencing controller for the five-stage LEGv8 core: load-use bubbles,
// branch squash, data-memory freeze with timeout fault, and saturating perf counters.
module hazard_ctl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNTW    = 16,
    localparam int unsigned REGADDRSIZE = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idex_memread,
    input  logic [REGADDRSIZE-1:0] idex_rd,
    input  logic [REGADDRSIZE-1:0] ifid_ra,
    input  logic [REGADDRSIZE-1:0] ifid_rb,
    input  logic                   exmem_memaccess,
    input  logic                   dmem_ready,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   idex_write,
    output logic                   exmem_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic                   mem_fault,
    output logic [CNTW-1:0]        stall_cycles,
    output logic [CNTW-1:0]        flush_count
);

    localparam int unsigned WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [REGADDRSIZE-1:0] XZR = REGADDRSIZE'(31);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [WCW-1:0]     r_wcnt;
    logic               r_fault;
    logic [CNTW-1:0]    r_stall;
    logic [CNTW-1:0]    r_flush;

    state_t             w_next_state;
    logic [WCW-1:0]     w_next_wcnt;
    logic               w_set_fault;
    logic               w_inc_stall;
    logic               w_inc_flush;
    logic               w_memstall;
    logic               w_loaduse;

    assign w_memstall = exmem_memaccess && !dmem_ready;
    assign w_loaduse  = idex_memread && (idex_rd != XZR) &&
                        ((idex_rd == ifid_ra) || (idex_rd == ifid_rb));

    // Next state and same-cycle stage-register controls, in priority order.
    always_comb begin
        w_next_state = r_state;
        w_next_wcnt  = r_wcnt;
        w_set_fault  = 1'b0;
        w_inc_stall  = 1'b0;
        w_inc_flush  = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;

        if (r_state == S_FAULT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (w_memstall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
            w_inc_stall = 1'b1;
            if (r_wcnt == WCW'(TIMEOUT)) begin
                w_next_state = S_FAULT;
                w_set_fault  = 1'b1;
            end else begin
                w_next_state = S_WAIT;
                w_next_wcnt  = r_wcnt + WCW'(1);
            end
        end else begin
            w_next_state = S_RUN;
            w_next_wcnt  = '0;
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                w_inc_flush = 1'b1;
            end else if (w_loaduse) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
                w_inc_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_wcnt  <= '0;
            r_fault <= 1'b0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_next_wcnt;
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            // Perf counters hold at all-ones rather than wrapping.
            if (w_inc_stall && (r_stall != '1)) begin
                r_stall <= r_stall + CNTW'(1);
            end
            if (w_inc_flush && (r_flush != '1)) begin
                r_flush <= r_flush + CNTW'(1);
            end
        end
    end

    assign mem_fault    = r_fault;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

endmodule
